// File: rtl/rand_roller_pkg.sv
// rand_roller_pkg: shared state type, default parameters and default Galois tap masks
// for the rand_roller dice-style random number roller.
package rand_roller_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ROLL = 1'b1
  } roll_state_e;

  localparam logic [3:0]  TAPS_W4  = 4'hC;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;

  localparam int DEF_OUT_W          = 4;
  localparam int DEF_LFSR_W         = 16;
  localparam int DEF_START_INTERVAL = 2048;
  localparam int DEF_STEPS          = 19;
  localparam int DEF_HIST_DEPTH     = 4;

  // Width of the step-interval register and cycle counter; doubling saturates here.
  localparam int INTERVAL_W = 16;

  // Tap mask for the common widths; LFSR_W is limited to 32 bits.
  function automatic logic [31:0] default_taps(input int lfsr_w);
    case (lfsr_w)
      4:       return 32'(TAPS_W4);
      8:       return 32'(TAPS_W8);
      default: return 32'(TAPS_W16);
    endcase
  endfunction

endpackage

// File: rtl/rand_lfsr.sv
// rand_lfsr: Galois LFSR that loads a seed (zero mapped to 1) while load is high
// and advances one position on each cycle that step is high.
module rand_lfsr
  import rand_roller_pkg::*;
#(
  parameter int                LFSR_W = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(default_taps(LFSR_W))
) (
  input  logic              i_clk,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q, state_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed == '0) ? LFSR_W'(1) : seed;
    end else if (step) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  // Deliberately no reset: the seed is loaded on each clock while the roller is held
  // in reset, so the clock must run and i_seed must be stable during reset.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/rand_roller.sv
// rand_roller: LFSR dice roller whose step interval doubles until it settles on a result.
// Define RAND_ROLLER_TRACE_EN to add a result history that i_trace walks through.
module rand_roller
  import rand_roller_pkg::*;
#(
  parameter int                OUT_W          = DEF_OUT_W,
  parameter int                LFSR_W         = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS           = LFSR_W'(default_taps(LFSR_W)),
  parameter int                START_INTERVAL = DEF_START_INTERVAL,
  parameter int                STEPS          = DEF_STEPS,
  parameter int                HIST_DEPTH     = DEF_HIST_DEPTH
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic                          i_trace,
  input  logic [LFSR_W-1:0]             i_seed,
  output logic [OUT_W-1:0]              o_random_out,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [$clog2(HIST_DEPTH)-1:0] o_hist_idx
);

  localparam int IW    = INTERVAL_W;
  localparam int SW    = $clog2(STEPS + 1);
  localparam int IDX_W = $clog2(HIST_DEPTH);

  roll_state_e       state_q, state_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     ival_q, ival_d;
  logic [SW-1:0]     steps_q, steps_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              done_q, done_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic              lfsr_load;
  logic              lfsr_step;
  logic [LFSR_W-1:0] lfsr_state;
  logic [OUT_W-1:0]  step_val;
  logic              step_hit;
  logic              last_step;

  assign lfsr_load = ~i_rst_n;

  rand_lfsr #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS)
  ) u_lfsr (
    .i_clk (i_clk),
    .load  (lfsr_load),
    .seed  (i_seed),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  // Low bits of the value the LFSR takes on this step.
  assign step_val  = OUT_W'(lfsr_state >> 1) ^ (lfsr_state[0] ? TAPS[OUT_W-1:0] : '0);
  assign step_hit  = (cnt_q == ival_q - IW'(1));
  assign last_step = step_hit && (steps_q == SW'(STEPS - 1));

`ifdef RAND_ROLLER_TRACE_EN
  localparam int VW = $clog2(HIST_DEPTH + 1);

  logic [OUT_W-1:0] hist_q [HIST_DEPTH];
  logic [VW-1:0]    valid_q, valid_d;
  logic [IDX_W-1:0] trace_idx;

  assign trace_idx = (VW'(idx_q) + VW'(1) >= valid_q) ? '0 : idx_q + IDX_W'(1);

  always_comb begin
    valid_d = valid_q;
    if (done_d && valid_q != VW'(HIST_DEPTH)) valid_d = valid_q + VW'(1);
  end

  // NOTE: history storage is not reset; valid_q alone decides which entries are meaningful.
  always_ff @(posedge i_clk) begin
    if (done_d) begin
      hist_q[0] <= out_d;
      for (int i = 1; i < HIST_DEPTH; i++) hist_q[i] <= hist_q[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) valid_q <= '0;
    else          valid_q <= valid_d;
  end
`else
  logic unused_trace;
  assign unused_trace = i_trace;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ival_d    = ival_q;
    steps_d   = steps_q;
    out_d     = out_q;
    done_d    = 1'b0;
    idx_d     = idx_q;
    lfsr_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = ROLL;
          cnt_d   = '0;
          steps_d = '0;
          ival_d  = IW'(START_INTERVAL);
          out_d   = lfsr_state[OUT_W-1:0];
          idx_d   = '0;
        end
`ifdef RAND_ROLLER_TRACE_EN
        else if (i_trace && valid_q >= VW'(2)) begin
          idx_d = trace_idx;
          out_d = hist_q[trace_idx];
        end
`endif
      end
      ROLL: begin
        // A final step landing with i_start still commits once; otherwise i_start stops at once.
        if (i_start && !last_step) begin
          state_d = IDLE;
          done_d  = 1'b1;
          idx_d   = '0;
        end else if (step_hit) begin
          lfsr_step = 1'b1;
          cnt_d     = '0;
          ival_d    = ival_q[IW-1] ? '1 : (ival_q << 1);
          steps_d   = steps_q + SW'(1);
          out_d     = step_val;
          if (last_step) begin
            state_d = IDLE;
            done_d  = 1'b1;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ival_q  <= '0;
      steps_q <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ival_q  <= ival_d;
      steps_q <= steps_d;
      out_q   <= out_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
    end
  end

  assign o_random_out = out_q;
  assign o_busy       = (state_q == ROLL);
  assign o_done       = done_q;
  assign o_hist_idx   = idx_q;

endmodule

// File: tb/tb_rand_roller.sv
// tb_rand_roller: directed and random stimulus checked cycle by cycle against a
// schedule-based model of the roller (elapsed time vs. cumulative step deadlines).
module tb_rand_roller;

  localparam int         OUT_W          = 4;
  localparam int         LFSR_W         = 4;
  localparam logic [3:0] TAPS           = 4'hC;
  localparam int         START_INTERVAL = 4;
  localparam int         STEPS          = 3;
  localparam int         HIST_DEPTH     = 4;
`ifdef RAND_ROLLER_TRACE_EN
  localparam bit TRACE_EN = 1'b1;
`else
  localparam bit TRACE_EN = 1'b0;
`endif

  logic             i_clk   = 1'b0;
  logic             i_rst_n = 1'b1;
  logic             i_start = 1'b0;
  logic             i_trace = 1'b0;
  logic [3:0]       i_seed  = 4'h0;
  logic [OUT_W-1:0] o_random_out;
  logic             o_busy;
  logic             o_done;
  logic [1:0]       o_hist_idx;

  rand_roller #(
    .OUT_W          (OUT_W),
    .LFSR_W         (LFSR_W),
    .TAPS           (TAPS),
    .START_INTERVAL (START_INTERVAL),
    .STEPS          (STEPS),
    .HIST_DEPTH     (HIST_DEPTH)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_trace      (i_trace),
    .i_seed       (i_seed),
    .o_random_out (o_random_out),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_hist_idx   (o_hist_idx)
  );

  always #5 i_clk = ~i_clk;

  int    n_checks = 0;
  int    n_errors = 0;
  string phase    = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s got=%0d expected=%0d at %0t", phase, tag, got, exp, $time);
    end
  endtask

  // Reference model: a roll is a list of deadlines measured from the start edge.
  int m_lfsr, m_out, m_idx, m_elapsed, m_next_at, m_nsteps;
  bit m_busy, m_done;
  int hist[$];
  int last_done_val;
  int n_done;

  function automatic int galois(input int v);
    return (v >> 1) ^ (((v & 1) != 0) ? int'(TAPS) : 0);
  endfunction

  function automatic int interval_after(input int n);
    longint v;
    v = longint'(START_INTERVAL) << n;
    return (v > 65535) ? 65535 : int'(v);
  endfunction

  task automatic model_reset(input int seed);
    m_lfsr = (seed == 0) ? 1 : seed;
    m_out = 0; m_idx = 0; m_busy = 0; m_done = 0;
    hist.delete();
  endtask

  task automatic model_commit(input int v);
    m_busy = 0; m_done = 1; m_idx = 0;
    if (TRACE_EN) begin
      hist.push_front(v);
      if (hist.size() > HIST_DEPTH) void'(hist.pop_back());
    end
  endtask

  task automatic model_edge(input bit start, input bit trace);
    bit boundary, final_step;
    m_done = 0;
    if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_elapsed = 0; m_nsteps = 0;
        m_next_at = interval_after(0);
        m_out = m_lfsr & 32'hF; m_idx = 0;
      end else if (trace && TRACE_EN && hist.size() >= 2) begin
        m_idx = (m_idx + 1) % hist.size();
        m_out = hist[m_idx];
      end
    end else begin
      m_elapsed++;
      boundary   = (m_elapsed == m_next_at);
      final_step = boundary && (m_nsteps + 1 == STEPS);
      if (start && !final_step) begin
        model_commit(m_out);
      end else if (boundary) begin
        m_lfsr = galois(m_lfsr);
        m_out = m_lfsr & 32'hF;
        m_nsteps++;
        m_next_at += interval_after(m_nsteps);
        if (m_nsteps == STEPS) model_commit(m_out);
      end
    end
  endtask

  // One clock: drive inputs, let the edge happen, then compare just after it.
  task automatic cycle(input bit start, input bit trace);
    i_start = start; i_trace = trace;
    @(posedge i_clk);
    model_edge(start, trace);
    #1;
    check("out",  o_random_out, m_out);
    check("busy", o_busy,       m_busy);
    check("done", o_done,       m_done);
    check("idx",  o_hist_idx,   m_idx);
    if (o_done) begin
      last_done_val = o_random_out;
      n_done++;
    end
    i_start = 1'b0; i_trace = 1'b0;
  endtask

  task automatic do_reset(input logic [3:0] seed);
    i_start = 1'b0; i_trace = 1'b0; i_seed = seed;
    i_rst_n = 1'b0;
    #1;
    check("rst_out",  o_random_out, 0);
    check("rst_busy", o_busy,       0);
    check("rst_done", o_done,       0);
    check("rst_idx",  o_hist_idx,   0);
    repeat (2) @(posedge i_clk);
    model_reset(seed);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_seed  = 4'($urandom_range(0, 15));
  endtask

  task automatic run_until_idle(input int max_cycles);
    for (int i = 0; i < max_cycles && m_busy; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++)
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    run_until_idle(64);
  endtask

  initial begin
    int done_before;
    #2;
    phase = "reset";
    do_reset(4'h1);

    phase = "seed1_roll";
    last_done_val = -1;
    cycle(1'b1, 1'b0);
    check("start_value", o_random_out, 1);
    run_until_idle(64);
    check("result", last_done_val, 3);

    phase = "seed0_roll";
    do_reset(4'h0);
    last_done_val = -1;
    cycle(1'b1, 1'b0);
    run_until_idle(64);
    check("result", last_done_val, 3);

    phase = "early_stop";
    do_reset(4'h1);
    last_done_val = -1;
    cycle(1'b1, 1'b0);
    repeat (6) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    check("stop_value", last_done_val, 12);

    phase = "start_on_final_step";
    do_reset(4'h1);
    last_done_val = -1;
    cycle(1'b1, 1'b0);
    repeat (27) cycle(1'b0, 1'b0);
    done_before = n_done;
    cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0);
    check("commits", n_done - done_before, 1);
    check("result", last_done_val, 3);

    phase = "fill_history";
    for (int r = 0; r < 5; r++) begin
      cycle(1'b1, 1'b0);
      repeat ($urandom_range(1, 26)) cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      run_until_idle(64);
    end
    phase = "trace_walk";
    repeat (4) cycle(1'b0, 1'b1);

    phase = "start_and_trace";
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    run_until_idle(64);
    repeat (3) cycle(1'b0, 1'b1);

    phase = "random";
    random_cycles(600);
    for (int s = 0; s < 3; s++) begin
      phase = "random_seed";
      do_reset(4'($urandom_range(0, 15)));
      random_cycles(150);
    end

    phase = "reset_mid_roll";
    cycle(1'b1, 1'b0);
    repeat (10) cycle(1'b0, 1'b0);
    do_reset(4'($urandom_range(0, 15)));
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    random_cycles(100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
